// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - LOOK request scheduler driving the four-floor elevator floor machine
//
// Ports:
//   CLK            clock, all state updates on the rising edge
//   RST_N          asynchronous active-low reset
//   call_req[3:0]  per-floor call buttons, bit i = floor i+1 (level or pulse)
//   floor_in[2:0]  current floor from the floor machine, encoded 1..4
//   stop_go        to floor machine, 0 = step one floor this cycle
//   up_down        to floor machine, step direction (1 = up)
//   door_open      high during door dwell at a served floor
//   moving         high while stepping or travelling between floors
//   pending[3:0]   registered outstanding requests
//   fault          sticky, set when floor_in is outside 1..4
module elevator_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] call_req,
  input  logic [2:0] floor_in,
  output logic       stop_go,
  output logic       up_down,
  output logic       door_open,
  output logic       moving,
  output logic [3:0] pending,
  output logic       fault
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STEP   = 2'd1;
  localparam logic [1:0] S_TRAVEL = 2'd2;
  localparam logic [1:0] S_DOOR   = 2'd3;

  localparam logic [7:0] TRAVEL_LD = 8'(TRAVEL_CYCLES);
  localparam logic [7:0] DOOR_LD   = 8'(DOOR_CYCLES);

  logic [1:0] state;
  logic [7:0] timer;
  logic       dir;

  logic       floor_ok;
  logic [1:0] cur;
  logic [3:0] cur_bit;
  logic [3:0] above;
  logic [3:0] below;
  logic [3:0] call_keep;
  logic       door_press;
  logic       evaluate;
  logic       dec_door;
  logic       dec_step;
  logic       dec_dir;
  logic [1:0] dec_state;
  logic [7:0] dec_timer;
  logic       enter_door;

  always_comb begin
    floor_ok = (floor_in >= 3'd1) && (floor_in <= 3'd4);
    cur      = floor_in[1:0] - 2'd1;
    cur_bit  = 4'd1 << cur;
    // Bits strictly above / below the current floor; at floor 4 the shifted
    // mask wraps to zero so "above" is empty.
    above    = pending & ~((cur_bit << 1) - 4'd1);
    below    = pending & (cur_bit - 4'd1);

    // A re-press of the current floor while the door is open holds the door
    // rather than queueing a request that would reopen it later.
    door_press = (state == S_DOOR) && floor_ok && (|(call_req & cur_bit));
    call_keep  = ((state == S_DOOR) && floor_ok) ? (call_req & ~cur_bit) : call_req;

    evaluate = (state == S_IDLE) ||
               ((state == S_TRAVEL) && (timer == 8'd1)) ||
               ((state == S_DOOR) && !door_press && (timer == 8'd1));

    // LOOK decision: serve here, else continue ahead, else reverse, else idle.
    dec_door = |(pending & cur_bit);
    dec_step = 1'b0;
    dec_dir  = dir;
    if (!dec_door) begin
      if (dir ? (|above) : (|below)) begin
        dec_step = 1'b1;
      end else if (dir ? (|below) : (|above)) begin
        dec_step = 1'b1;
        dec_dir  = ~dir;
      end
    end
    dec_state = dec_door ? S_DOOR : (dec_step ? S_STEP : S_IDLE);
    dec_timer = dec_door ? DOOR_LD : 8'd0;

    enter_door = !fault && floor_ok && evaluate && dec_door;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_IDLE;
      timer   <= 8'd0;
      dir     <= 1'b1;
      pending <= 4'd0;
      fault   <= 1'b0;
    end else begin
      // Clear beats set: a call for this floor on the door-entry edge is
      // served by that door opening.
      pending <= (pending | call_keep) & ~(enter_door ? cur_bit : 4'd0);
      if (!floor_ok) begin
        fault <= 1'b1;
      end
      if (fault || !floor_ok) begin
        state <= S_IDLE;
        timer <= 8'd0;
      end else if (evaluate) begin
        state <= dec_state;
        timer <= dec_timer;
        dir   <= dec_dir;
      end else begin
        case (state)
          S_STEP: begin
            state <= S_TRAVEL;
            timer <= TRAVEL_LD;
          end
          S_TRAVEL: timer <= timer - 8'd1;
          S_DOOR:   timer <= door_press ? DOOR_LD : (timer - 8'd1);
          default:  timer <= 8'd0;
        endcase
      end
    end
  end

  // Outputs decode straight from registers so reset takes effect immediately.
  // dir only changes on entry to STEP, so it doubles as the held up_down.
  assign stop_go   = (state != S_STEP);
  assign up_down   = dir;
  assign door_open = (state == S_DOOR);
  assign moving    = (state == S_STEP) || (state == S_TRAVEL);

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb/tb_elevator_scheduler.sv - directed-vector bench for elevator_scheduler with a behavioural floor machine
module tb_elevator_scheduler;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [3:0] call_req = 4'd0;
  logic [2:0] floor_in;
  logic       stop_go;
  logic       up_down;
  logic       door_open;
  logic       moving;
  logic [3:0] pending;
  logic       fault;

  logic [2:0] floor_q = 3'd1;
  logic       set_floor_en = 1'b0;
  logic [2:0] set_floor_val = 3'd1;
  logic       floor_bad = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  assign floor_in = floor_bad ? 3'd0 : floor_q;

  elevator_scheduler #(.TRAVEL_CYCLES(8), .DOOR_CYCLES(16)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .call_req  (call_req),
    .floor_in  (floor_in),
    .stop_go   (stop_go),
    .up_down   (up_down),
    .door_open (door_open),
    .moving    (moving),
    .pending   (pending),
    .fault     (fault)
  );

  // Floor machine: moves one floor on the edge that ends a stop_go=0 cycle.
  always @(posedge CLK) begin
    if (set_floor_en)
      floor_q <= set_floor_val;
    else if (stop_go == 1'b0)
      floor_q <= up_down ? floor_q + 3'd1 : floor_q - 3'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Never step past the top or bottom floor.
  always @(negedge CLK) begin
    if (RST_N && stop_go == 1'b0)
      check_val("step_bound", 32'(up_down ? (floor_in != 3'd4) : (floor_in != 3'd1)), 32'd1);
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [2:0] fl);
    RST_N = 1'b0;
    call_req = 4'd0;
    floor_bad = 1'b0;
    set_floor_en = 1'b1;
    set_floor_val = fl;
    step();
    step();
    set_floor_en = 1'b0;
    RST_N = 1'b1;
  endtask

  task automatic wait_for_door(input string tag);
    int k;
    k = 0;
    while (door_open !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    check_val(tag, 32'(door_open), 32'd1);
  endtask

  task automatic wait_for_close(input string tag);
    int k;
    k = 0;
    while (door_open !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    check_val(tag, 32'(door_open), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, lows, first_low, second_low, bad_dir, ndoors, nsteps, flips;
    logic low_seen, pend_seen, prev_door, mov_seen;
    logic [7:0] seq;
    logic [2:0] door_fl0, door_fl1;

    // Reset values
    RST_N = 1'b0;
    set_floor_en = 1'b1;
    set_floor_val = 3'd1;
    step();
    check_val("rst_stop_go", 32'(stop_go), 32'd1);
    check_val("rst_up_down", 32'(up_down), 32'd1);
    check_val("rst_door", 32'(door_open), 32'd0);
    check_val("rst_moving", 32'(moving), 32'd0);
    check_val("rst_pending", 32'(pending), 32'd0);
    check_val("rst_fault", 32'(fault), 32'd0);
    step();
    set_floor_en = 1'b0;
    RST_N = 1'b1;

    // Idle call at current floor 1
    call_req = 4'b0001;
    step();
    call_req = 4'd0;
    check_val("idle_pend_set", 32'(pending), 32'h1);
    check_val("idle_door_early", 32'(door_open), 32'd0);
    step();
    check_val("idle_door_start", 32'(door_open), 32'd1);
    n = 0;
    low_seen = 1'b0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      if (stop_go !== 1'b1) low_seen = 1'b1;
      step();
    end
    check_val("idle_door_len", 32'(n), 32'd16);
    check_val("idle_pend_clr", 32'(pending), 32'h0);
    check_val("idle_no_step", 32'(low_seen), 32'd0);
    check_val("idle_stop_go", 32'(stop_go), 32'd1);

    // Travel 1 -> 3
    call_req = 4'b0100;
    step();
    call_req = 4'd0;
    k = 0; lows = 0; first_low = -1; second_low = -1; bad_dir = 0;
    while (door_open !== 1'b1 && k < 100) begin
      step();
      k++;
      if (stop_go === 1'b0) begin
        lows++;
        if (lows == 1) first_low = k;
        else if (lows == 2) second_low = k;
        if (up_down !== 1'b1) bad_dir++;
      end
    end
    check_val("trav_steps", 32'(lows), 32'd2);
    check_val("trav_first", 32'(first_low), 32'd1);
    check_val("trav_second", 32'(second_low), 32'd10);
    check_val("trav_door_at", 32'(k), 32'd19);
    check_val("trav_dir", 32'(bad_dir), 32'd0);
    check_val("trav_floor", 32'(floor_in), 32'd3);
    wait_for_close("trav_close");

    // LOOK reversal: at floor 2 heading up with calls for 1 and 4
    do_reset(3'd1);
    call_req = 4'b0010;
    step();
    call_req = 4'd0;
    wait_for_door("look_door2");
    check_val("look_floor2", 32'(floor_in), 32'd2);
    call_req = 4'b1001;
    step();
    call_req = 4'd0;
    check_val("look_pend", 32'(pending), 32'h9);
    seq = 8'd0; nsteps = 0; ndoors = 0; prev_door = 1'b1; k = 0;
    door_fl0 = 3'd0; door_fl1 = 3'd0;
    while (!(ndoors == 2 && door_open === 1'b0) && k < 400) begin
      step();
      k++;
      if (stop_go === 1'b0) begin
        seq = {seq[6:0], up_down};
        nsteps++;
      end
      if (door_open === 1'b1 && prev_door === 1'b0) begin
        ndoors++;
        if (ndoors == 1) door_fl0 = floor_in;
        else door_fl1 = floor_in;
      end
      prev_door = door_open;
    end
    flips = 0;
    for (int i = 1; i < nsteps && i < 8; i++)
      if (seq[i] != seq[i-1]) flips++;
    check_val("look_nsteps", 32'(nsteps), 32'd5);
    check_val("look_seq", 32'(seq[4:0]), 32'b11000);
    check_val("look_first_door", 32'(door_fl0), 32'd4);
    check_val("look_second_door", 32'(door_fl1), 32'd1);
    check_val("look_flips", 32'(flips), 32'd1);
    check_val("look_pend_done", 32'(pending), 32'h0);

    // Door hold at floor 3: re-press on dwell cycle 10
    do_reset(3'd1);
    call_req = 4'b0100;
    step();
    call_req = 4'd0;
    wait_for_door("hold_door");
    check_val("hold_floor", 32'(floor_in), 32'd3);
    n = 0;
    pend_seen = 1'b0;
    while (door_open === 1'b1 && n < 100) begin
      n++;
      if (n == 10) call_req = 4'b0100;
      step();
      call_req = 4'd0;
      if (pending[2] !== 1'b0) pend_seen = 1'b1;
    end
    check_val("hold_len", 32'(n), 32'd26);
    check_val("hold_pend", 32'(pend_seen), 32'd0);

    // Set and clear of pending[cur] on the same (door-entry) edge
    do_reset(3'd1);
    call_req = 4'b0100;
    step();
    call_req = 4'd0;
    repeat (18) step();
    check_val("sc_pre_moving", 32'(moving), 32'd1);
    check_val("sc_pre_door", 32'(door_open), 32'd0);
    call_req = 4'b0100;
    step();
    call_req = 4'd0;
    check_val("sc_door", 32'(door_open), 32'd1);
    check_val("sc_pend", 32'(pending), 32'h0);

    // Fault: invalid floor while idle, request arriving on the same edge
    do_reset(3'd1);
    call_req = 4'b0010;
    floor_bad = 1'b1;
    step();
    call_req = 4'd0;
    check_val("flt_set", 32'(fault), 32'd1);
    check_val("flt_pend", 32'(pending), 32'h2);
    check_val("flt_stop_go", 32'(stop_go), 32'd1);
    floor_bad = 1'b0;
    low_seen = 1'b0;
    mov_seen = 1'b0;
    repeat (20) begin
      step();
      if (stop_go !== 1'b1) low_seen = 1'b1;
      if (moving !== 1'b0) mov_seen = 1'b1;
    end
    check_val("flt_stuck", 32'(low_seen), 32'd0);
    check_val("flt_no_move", 32'(mov_seen), 32'd0);
    check_val("flt_sticky", 32'(fault), 32'd1);
    call_req = 4'b1000;
    step();
    call_req = 4'd0;
    check_val("flt_accum", 32'(pending), 32'hA);

    // Asynchronous reset mid-travel (heading down from floor 4)
    do_reset(3'd4);
    call_req = 4'b0001;
    step();
    call_req = 4'd0;
    repeat (4) step();
    check_val("ar_pre_moving", 32'(moving), 32'd1);
    check_val("ar_pre_dir", 32'(up_down), 32'd0);
    check_val("ar_pre_pend", 32'(pending), 32'h1);
    #2;
    RST_N = 1'b0;
    #1;
    check_val("ar_stop_go", 32'(stop_go), 32'd1);
    check_val("ar_up_down", 32'(up_down), 32'd1);
    check_val("ar_door", 32'(door_open), 32'd0);
    check_val("ar_moving", 32'(moving), 32'd0);
    check_val("ar_pending", 32'(pending), 32'h0);
    check_val("ar_fault", 32'(fault), 32'd0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
